// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared state encoding and defaults for the button event decoder
//
// Contents:
//   state_t            FSM state encoding (IDLE, PRESSED, LONG_HELD, WAIT_RELEASE)
//   DEFAULT_CNT_WIDTH  default width of the hold counter
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESSED      = 2'd1,
        LONG_HELD    = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam int DEFAULT_CNT_WIDTH = 32;

endpackage

// File: rtl/button_event_decoder_hold_timer.sv
// rtl/button_event_decoder_hold_timer.sv - hold-duration up-counter with selectable terminal count
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear of the count (wins over inc)
//   inc         advance the count by one
//   sel_repeat  0: compare against LONG_PRESS_CYCLES-1, 1: against REPEAT_CYCLES-1
//   terminal    1 while the count equals the selected limit minus one
module button_event_decoder_hold_timer
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int REPEAT_CYCLES     = 10000000,
    parameter int CNT_WIDTH         = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    input  logic sel_repeat,
    output logic terminal
);

    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] hold_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
        end else if (inc) begin
            hold_cnt <= hold_cnt + CNT_ONE;
        end
    end

    // The flag is raised on the count value seen at the edge that should act,
    // so the FSM transitions exactly LIMIT edges after the counter was cleared.
    assign terminal = (hold_cnt == (sel_repeat ? REPEAT_LAST : LONG_LAST));

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/release/click/long/repeat events
//
// Ports:
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   button_level      debounced level, synchronous to clk, 1 = pressed
//   enable            0 suppresses all events and parks the FSM
//   press_pulse       one cycle on a new press
//   release_pulse     one cycle on any release
//   click_pulse       one cycle on release before the long-press threshold
//   long_press_pulse  one cycle when the hold reaches LONG_PRESS_CYCLES
//   repeat_pulse      one cycle every REPEAT_CYCLES while long-held
//   held              1 while the state is PRESSED or LONG_HELD
//   press_count       wrapping count of press_pulse events
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int REPEAT_CYCLES     = 10000000,
    parameter int CNT_WIDTH         = DEFAULT_CNT_WIDTH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_level,
    input  logic       enable,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       long_press_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    state_t state;
    state_t next_state;

    logic cnt_clear;
    logic cnt_inc;
    logic terminal;

    logic nxt_press;
    logic nxt_release;
    logic nxt_click;
    logic nxt_long;
    logic nxt_repeat;

    button_event_decoder_hold_timer #(
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .REPEAT_CYCLES     (REPEAT_CYCLES),
        .CNT_WIDTH         (CNT_WIDTH)
    ) u_hold_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .inc        (cnt_inc),
        .sel_repeat (state == LONG_HELD),
        .terminal   (terminal)
    );

    // The counter is cleared on every path except a plain continued hold, so
    // entering PRESSED or LONG_HELD always starts from zero.
    always_comb begin
        next_state  = state;
        cnt_clear   = 1'b1;
        cnt_inc     = 1'b0;
        nxt_press   = 1'b0;
        nxt_release = 1'b0;
        nxt_click   = 1'b0;
        nxt_long    = 1'b0;
        nxt_repeat  = 1'b0;

        if (!enable) begin
            // Parking in WAIT_RELEASE while pressed prevents a phantom press
            // when enable comes back with the button still down.
            next_state = button_level ? WAIT_RELEASE : IDLE;
        end else begin
            case (state)
                WAIT_RELEASE: begin
                    if (!button_level) begin
                        next_state = IDLE;
                    end
                end
                IDLE: begin
                    if (button_level) begin
                        next_state = PRESSED;
                        nxt_press  = 1'b1;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over the threshold edge.
                    if (!button_level) begin
                        next_state  = IDLE;
                        nxt_release = 1'b1;
                        nxt_click   = 1'b1;
                    end else if (terminal) begin
                        next_state = LONG_HELD;
                        nxt_long   = 1'b1;
                    end else begin
                        cnt_clear = 1'b0;
                        cnt_inc   = 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (!button_level) begin
                        next_state  = IDLE;
                        nxt_release = 1'b1;
                    end else if (terminal) begin
                        nxt_repeat = 1'b1;
                    end else begin
                        cnt_clear = 1'b0;
                        cnt_inc   = 1'b1;
                    end
                end
                default: begin
                    next_state = WAIT_RELEASE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= WAIT_RELEASE;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            click_pulse      <= 1'b0;
            long_press_pulse <= 1'b0;
            repeat_pulse     <= 1'b0;
            held             <= 1'b0;
            press_count      <= 8'd0;
        end else begin
            state            <= next_state;
            press_pulse      <= nxt_press;
            release_pulse    <= nxt_release;
            click_pulse      <= nxt_click;
            long_press_pulse <= nxt_long;
            repeat_pulse     <= nxt_repeat;
            held             <= (next_state == PRESSED) || (next_state == LONG_HELD);
            if (nxt_press) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed self-checking bench for button_event_decoder
module tb_button_event_decoder;

    logic       clk;
    logic       reset_n;
    logic       button_level;
    logic       enable;
    logic       press_pulse;
    logic       release_pulse;
    logic       click_pulse;
    logic       long_press_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    int checks;
    int failures;

    logic [5:0] got;
    logic [5:0] exp;

    button_event_decoder #(
        .LONG_PRESS_CYCLES (8),
        .REPEAT_CYCLES     (4),
        .CNT_WIDTH         (32)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .button_level     (button_level),
        .enable           (enable),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .click_pulse      (click_pulse),
        .long_press_pulse (long_press_pulse),
        .repeat_pulse     (repeat_pulse),
        .held             (held),
        .press_count      (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // got/exp bit order: {press, release, click, long, repeat, held}
    function automatic logic [5:0] outs();
        return {press_pulse, release_pulse, click_pulse, long_press_pulse, repeat_pulse, held};
    endfunction

    task automatic step(input logic b, input logic en);
        button_level = b;
        enable       = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic b);
        @(posedge clk);
        #1;
        reset_n      = 1'b0;
        button_level = b;
        enable       = 1'b1;
        #12;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset_n      = 1'b0;
        button_level = 1'b0;
        enable       = 1'b1;
        #2;
        checks++;
        got = outs();
        if (got !== 6'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: got outs=%b count=%0d, required outs=000000 count=0", got, press_count);
        end
        #10;
        reset_n = 1'b1;
        step(1'b0, 1'b1);
        checks++;
        if (outs() !== 6'b0) begin
            failures++;
            $display("FAIL reset_to_idle: got outs=%b, required 000000", outs());
        end
    endtask

    task automatic test_short_click();
        for (int i = 0; i < 8; i++) begin
            step(i < 5, 1'b1);
            exp = {i == 0, i == 5, i == 5, 1'b0, 1'b0, i < 5};
            got = outs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL short_click step %0d: got %b, required %b", i, got, exp);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            failures++;
            $display("FAIL short_click_count: got %0d, required 1", press_count);
        end
    endtask

    task automatic test_long_hold();
        for (int i = 0; i < 23; i++) begin
            step(i <= 20, 1'b1);
            exp = {i == 0, i == 21, 1'b0, i == 8, (i == 12) || (i == 16) || (i == 20), i <= 20};
            got = outs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL long_hold step %0d: got %b, required %b", i, got, exp);
            end
        end
        checks++;
        if (press_count !== 8'd2) begin
            failures++;
            $display("FAIL long_hold_count: got %0d, required 2", press_count);
        end
    endtask

    task automatic test_threshold_release();
        for (int i = 0; i < 10; i++) begin
            step(i < 8, 1'b1);
            exp = {i == 0, i == 8, i == 8, 1'b0, 1'b0, i < 8};
            got = outs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL threshold_release step %0d: got %b, required %b", i, got, exp);
            end
        end
        checks++;
        if (press_count !== 8'd3) begin
            failures++;
            $display("FAIL threshold_count: got %0d, required 3", press_count);
        end
    endtask

    task automatic test_held_through_reset();
        do_reset(1'b1);
        checks++;
        if (outs() !== 6'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL hold_reset_exit: got outs=%b count=%0d, required 000000 count=0", outs(), press_count);
        end
        // 10 held cycles, one release, one idle, press, hold, release
        for (int i = 0; i < 15; i++) begin
            step((i < 10) || (i == 12) || (i == 13), 1'b1);
            exp = {i == 12, i == 14, i == 14, 1'b0, 1'b0, (i == 12) || (i == 13)};
            got = outs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL held_through_reset step %0d: got %b, required %b", i, got, exp);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            failures++;
            $display("FAIL held_through_reset_count: got %0d, required 1", press_count);
        end
    endtask

    task automatic test_enable_mid_hold();
        logic b;
        logic en;
        for (int i = 0; i < 20; i++) begin
            b  = (i <= 14) || (i == 17);
            en = !((i == 3) || (i == 4));
            step(b, en);
            exp = {(i == 0) || (i == 17), i == 18, i == 18, 1'b0, 1'b0, (i <= 2) || (i == 17)};
            got = outs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL enable_mid_hold step %0d: got %b, required %b", i, got, exp);
            end
        end
        checks++;
        if (press_count !== 8'd3) begin
            failures++;
            $display("FAIL enable_mid_hold_count: got %0d, required 3", press_count);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [7:0] want;
        do_reset(1'b0);
        step(1'b0, 1'b1);
        for (int n = 0; n < 256; n++) begin
            want = 8'(n + 1);
            step(1'b1, 1'b1);
            got = outs();
            checks++;
            if (got !== 6'b100001 || press_count !== want) begin
                failures++;
                $display("FAIL wrap_press %0d: got outs=%b count=%0d, required 100001 count=%0d", n, got, press_count, want);
            end
            step(1'b0, 1'b1);
            got = outs();
            checks++;
            if (got !== 6'b011000) begin
                failures++;
                $display("FAIL wrap_release %0d: got %b, required 011000", n, got);
            end
        end
        checks++;
        if (press_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_final_count: got %0d, required 0", press_count);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        button_level = 1'b0;
        enable       = 1'b1;
        test_reset();
        test_short_click();
        test_long_hold();
        test_threshold_release();
        test_held_through_reset();
        test_enable_mid_hold();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
